add8_serial: RTL and testbench

ADD8_SERIAL -- requirements
Module: add8_serial

---
 rtl/add8_serial.sv | 122 ++++++++++++
 tb/tb_add8_serial.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/add8_serial.sv
// Nibble-serial adder: one 4-bit slice walks the operands LSB first and
// takes WIDTH/4 cycles per sum.
module add8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Co,
  output logic             V
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] sliceA, sliceB;
  logic [3:0] lowAdd;
  logic [1:0] msbAdd;

  // The slice is split at bit 3 so the carry into the MSB is visible for overflow.
  assign sliceA = opA_q[{idx_q, 2'b00} +: 4];
  assign sliceB = opB_q[{idx_q, 2'b00} +: 4];
  assign lowAdd = {1'b0, sliceA[2:0]} + {1'b0, sliceB[2:0]} + {3'b000, carry_q};
  assign msbAdd = {1'b0, sliceA[3]} + {1'b0, sliceB[3]} + {1'b0, lowAdd[3]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    f_d     = f_q;
    co_d    = co_q;
    v_d     = v_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = A;
          opB_d   = B;
          carry_d = Ci;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = {msbAdd[0], lowAdd[2:0]};
        carry_d = msbAdd[1];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          f_d     = sum_d;
          co_d    = msbAdd[1];
          v_d     = lowAdd[3] ^ msbAdd[1];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      f_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      f_q     <= f_d;
      co_q    <= co_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign F    = f_q;
  assign Co   = co_q;
  assign V    = v_q;

endmodule

// File: tb/tb_add8_serial.sv
// Directed bench for add8_serial (WIDTH=8): hand-computed sums, flags,
// handshake timing, back-to-back starts and mid-operation reset.
module tb_add8_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       Ci;
  logic       busy, done;
  logic [7:0] F;
  logic       Co, V;

  int total = 0;
  int bad   = 0;

  add8_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Ci(Ci),
    .busy(busy), .done(done), .F(F), .Co(Co), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [7:0] expF, input logic expCo, input logic expV);
    checkOutput({tag, ".busy"}, {7'd0, busy}, 8'd0);
    checkOutput({tag, ".done"}, {7'd0, done}, 8'd0);
    checkOutput({tag, ".F"}, F, expF);
    checkOutput({tag, ".Co"}, {7'd0, Co}, {7'd0, expCo});
    checkOutput({tag, ".V"}, {7'd0, V}, {7'd0, expV});
  endtask

  // One full addition: start accepted at the first edge, result after two more.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input logic [7:0] prevF, input logic [7:0] expF, input logic expCo, input logic expV);
    A = a; B = b; Ci = ci; start = 1'b1;
    tick();
    start = 1'b0; A = ~a; B = ~b; Ci = ~ci;
    checkOutput({tag, ".busy0"}, {7'd0, busy}, 8'd1);
    checkOutput({tag, ".done0"}, {7'd0, done}, 8'd0);
    checkOutput({tag, ".Fheld0"}, F, prevF);
    tick();
    checkOutput({tag, ".busy1"}, {7'd0, busy}, 8'd1);
    checkOutput({tag, ".done1"}, {7'd0, done}, 8'd0);
    checkOutput({tag, ".Fheld1"}, F, prevF);
    tick();
    checkOutput({tag, ".done"}, {7'd0, done}, 8'd1);
    checkOutput({tag, ".busy"}, {7'd0, busy}, 8'd0);
    checkOutput({tag, ".F"}, F, expF);
    checkOutput({tag, ".Co"}, {7'd0, Co}, {7'd0, expCo});
    checkOutput({tag, ".V"}, {7'd0, V}, {7'd0, expV});
    tick();
    checkIdle({tag, ".after"}, expF, expCo, expV);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; Ci = 1'b0;
    tick();
    tick();
    checkIdle("reset", 8'h00, 1'b0, 1'b0);

    // Start is high during reset; it must only be taken at the first released edge.
    start = 1'b1; A = 8'h99; B = 8'h99;
    tick();
    checkIdle("resetStart", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus("basic", 8'h3C, 8'h15, 1'b0, 8'h00, 8'h51, 1'b0, 1'b0);

    // Idle with start low holds every output.
    tick();
    tick();
    checkIdle("idleHold", 8'h51, 1'b0, 1'b0);

    applyStimulus("wrap", 8'hFF, 8'h01, 1'b0, 8'h51, 8'h00, 1'b1, 1'b0);
    applyStimulus("ovfPos", 8'h7F, 8'h01, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1);
    applyStimulus("nibCarry", 8'h0F, 8'h00, 1'b1, 8'h80, 8'h10, 1'b0, 1'b0);
    applyStimulus("allOnes", 8'hFF, 8'hFF, 1'b1, 8'h10, 8'hFF, 1'b1, 1'b0);
    applyStimulus("ovfNeg", 8'h80, 8'h80, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
    applyStimulus("mixed", 8'hA7, 8'h6B, 1'b1, 8'h00, 8'h13, 1'b1, 1'b0);

    // Start held high with operands churning during RUN, then back-to-back accept.
    A = 8'h12; B = 8'h34; Ci = 1'b0; start = 1'b1;
    tick();
    A = 8'hFF; B = 8'hFF; Ci = 1'b1;
    checkOutput("hold.busy0", {7'd0, busy}, 8'd1);
    tick();
    A = 8'hAA; B = 8'h55;
    checkOutput("hold.done1", {7'd0, done}, 8'd0);
    tick();
    A = 8'h01; B = 8'h02; Ci = 1'b0;
    checkOutput("hold.done", {7'd0, done}, 8'd1);
    checkOutput("hold.F", F, 8'h46);
    checkOutput("hold.Co", {7'd0, Co}, 8'd0);
    tick();
    A = 8'hC3; B = 8'h3C; Ci = 1'b1;
    checkOutput("b2b.doneLow", {7'd0, done}, 8'd0);
    checkOutput("b2b.busy0", {7'd0, busy}, 8'd1);
    checkOutput("b2b.Fheld", F, 8'h46);
    tick();
    start = 1'b0;
    checkOutput("b2b.done1", {7'd0, done}, 8'd0);
    tick();
    checkOutput("b2b.done", {7'd0, done}, 8'd1);
    checkOutput("b2b.F", F, 8'h03);
    checkOutput("b2b.V", {7'd0, V}, 8'd0);
    tick();
    checkIdle("b2b.after", 8'h03, 1'b0, 1'b0);

    // Reset one edge into an addition aborts it silently.
    A = 8'h3C; B = 8'h15; Ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; rst_n = 1'b0;
    checkOutput("abort.busy0", {7'd0, busy}, 8'd1);
    tick();
    checkIdle("abort", 8'h00, 1'b0, 1'b0);
    tick();
    checkIdle("abort.hold", 8'h00, 1'b0, 1'b0);
    tick();
    checkIdle("abort.noDone", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus("postReset", 8'h10, 8'h20, 1'b0, 8'h00, 8'h30, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
